md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, number of busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_LAT, default 10, number of busy cycles for div/divu.
REQ-003 SHALL have port Clk  input  1  rising-edge clock.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port A  input  32  operand rs; also the mthi/mtlo write data.
REQ-006 SHALL have port B  input  32  operand rt.
REQ-007 SHALL have port op  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mflo, 110 mthi, 111 mtlo.
REQ-008 SHALL have port start  input  1  qualifies op 000/001/010/011/110/111 for one cycle.
REQ-009 SHALL have port busy  output  1  high while a mult/div is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse on the cycle after HI/LO commit.
REQ-011 SHALL have port out  output  32  read data: HI when op==100, else LO.

Function
REQ-012 SHALL hold internal 32-bit registers HI and LO and states IDLE, MULT, DIV, plus a cycle counter.
REQ-013 SHALL, in IDLE, on a rising edge with start=1 and op in 000..011, latch A and B and enter MULT (000/001) or DIV (010/011), set busy=1 and load the counter.
REQ-014 SHALL keep busy=1 for exactly MULT_LAT (MULT) or DIV_LAT (DIV) cycles after the start edge, then return to IDLE with busy=0.
REQ-015 SHALL write HI/LO on the same edge on which busy falls, and assert done=1 for the following cycle only.
REQ-016 SHALL use the operands latched at the start edge, so A/B changes during busy have no effect.
REQ-017 SHALL compute mult as a signed 32x32 to 64-bit product and multu as unsigned, with HI=product[63:32] and LO=product[31:0].
REQ-018 SHALL compute div as signed with quotient truncated toward zero into LO and remainder carrying the dividend's sign into HI; divu SHALL be unsigned.
REQ-019 SHALL, for div 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0x00000000.
REQ-020 SHALL, when the divisor is 0, keep busy for the full DIV_LAT and pulse done, but leave HI and LO unchanged.
REQ-021 SHALL, in IDLE, on a rising edge with start=1 and op=110, write A into HI, and with op=111 write A into LO, with busy unaffected and done not pulsed.
REQ-022 SHALL ignore start, including mthi/mtlo, while busy=1, and SHALL NOT change HI/LO or restart the counter as a result.
REQ-023 SHALL drive out combinationally from HI/LO: it reflects committed values only, shows pre-operation values while busy, and does not depend on start.
REQ-024 SHALL ignore start with op 100/101, making them read-only with no state change.
REQ-025 SHALL accept a new start on the same edge that the previous operation commits only if busy was already 0 at that edge, so back-to-back issue gives a minimum of one idle cycle.

Reset
REQ-026 SHALL, while Reset=0 and immediately without waiting for a clock, set HI=0, LO=0, state IDLE, counter 0, busy=0, done=0, so out=0.
REQ-027 SHALL, when Reset is asserted mid-operation, abort the operation with no HI/LO commit and no done pulse.
REQ-028 SHALL ignore start on the first rising edge after Reset deasserts.

Verification
REQ-029 SHALL verify: mult A=0xFFFFFFFF, B=0x00000002, start one cycle -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE and done pulses once.
REQ-030 SHALL verify: multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-031 SHALL verify: div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu A=7, B=0 -> HI/LO unchanged, done pulses.
REQ-032 SHALL verify: mthi A=0x12345678, then op=100 -> out=0x12345678 in the next cycle; mtlo issued while busy -> LO unchanged after the mult commits.
REQ-033 SHALL verify: start a div, drive Reset=0 at cycle 4 -> busy=0, HI=LO=0 at once and no done pulse; after release, a new mult completes normally.
REQ-034 SHALL verify: start re-asserted every cycle during busy -> exactly one commit per operation and the counter is not restarted.

Source files
------------

// File: rtl/md_unit_if.sv
// Issue/result bundle for the multiply/divide unit.
// Master drives the request side; the unit answers with status and read data.
interface md_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] out;

    modport master (
        output A,
        output B,
        output op,
        output start,
        input  busy,
        input  done,
        input  out
    );

    modport slave (
        input  A,
        input  B,
        input  op,
        input  start,
        output busy,
        output done,
        output out
    );
endinterface

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit with fixed-latency mult/div and mthi/mtlo/mfhi/mflo.
// Results land in HI/LO on the edge busy falls; done follows for one cycle.
module md_unit #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic      Clk,
    input  logic      Reset,
    md_unit_if.slave  bus
);

    localparam int unsigned MAX_LAT =
        (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          sgn_q, sgn_d;
    logic          done_q, done_d;
    logic          armed_q;

    logic [63:0]   ma, mb, prod;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag;
    logic [31:0]   q_mag, r_mag;
    logic [31:0]   quot, rem;
    logic          accept;

    // Operands are sign- or zero-extended so one 64-bit multiply serves both.
    always_comb begin
        ma   = {{32{sgn_q & a_q[31]}}, a_q};
        mb   = {{32{sgn_q & b_q[31]}}, b_q};
        prod = ma * mb;
    end

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign; 0x80000000/-1 wraps to 0x80000000.
    always_comb begin
        a_neg = sgn_q & a_q[31];
        b_neg = sgn_q & b_q[31];
        a_mag = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag = b_neg ? (~b_q + 32'd1) : b_q;
        q_mag = '0;
        r_mag = '0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // armed_q blocks the first edge after reset release.
    assign accept = bus.start && armed_q && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d = MULT;
                            cnt_d   = CW'(MULT_LAT - 1);
                            a_d     = bus.A;
                            b_d     = bus.B;
                            sgn_d   = ~bus.op[0];
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = DIV;
                            cnt_d   = CW'(DIV_LAT - 1);
                            a_d     = bus.A;
                            b_d     = bus.B;
                            sgn_d   = ~bus.op[0];
                        end
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            MULT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DIV: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            done_q  <= done_d;
            armed_q <= 1'b1;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.out  = (bus.op == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expectations queued at issue,
// popped and compared against HI/LO when done pulses.
module tb_md_unit;

    localparam int MLAT = 5;
    localparam int DLAT = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    md_unit_if bus ();

    md_unit #(
        .MULT_LAT (MLAT),
        .DIV_LAT  (DLAT)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t            e;
        int              ia;
        int              ib;
        longint          p;
        longint unsigned pu;
        e.hi = hi_m;
        e.lo = lo_m;
        ia   = a;
        ib   = b;
        case (op)
            3'b000: begin
                p    = longint'(ia) * longint'(ib);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            3'b001: begin
                pu   = {32'b0, a} * {32'b0, b};
                e.hi = pu[63:32];
                e.lo = pu[31:0];
            end
            3'b010: begin
                if (ib != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = 32'h8000_0000;
                        e.hi = 32'h0;
                    end else begin
                        e.lo = ia / ib;
                        e.hi = ia % ib;
                    end
                end
            end
            3'b011: begin
                if (b != 0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic rd(input string tag);
        bus.op = 3'b100;
        #1 chk({tag, "_hi"}, bus.out, hi_m);
        bus.op = 3'b101;
        #1 chk({tag, "_lo"}, bus.out, lo_m);
    endtask

    // Called at a negedge; hammer re-asserts start with junk during busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hammer);
        int   lat;
        int   cyc;
        int   dn;
        exp_t e;
        lat       = op[1] ? DLAT : MLAT;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1 bus.start = hammer;
        if (hammer) begin
            bus.op = 3'b111;
            bus.A  = $urandom;
        end
        cyc = 0;
        dn  = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy) break;
            cyc++;
            if (bus.done) dn++;
            if (cyc > 4 * DLAT) break;
            if (hammer && cyc > 1) begin
                bus.op = 3'($urandom_range(0, 7));
                bus.A  = $urandom;
                bus.B  = $urandom;
            end
        end
        bus.start = 1'b0;
        chk("busy_cycles", 32'(cyc), 32'(lat));
        chk("done_early", 32'(dn), 32'd0);
        chk("done_pulse", 32'(bus.done), 32'd1);
        e    = sb.pop_front();
        hi_m = e.hi;
        lo_m = e.lo;
        @(negedge clk);
        chk("done_clear", 32'(bus.done), 32'd0);
        rd("result");
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] a);
        bus.op    = to_hi ? 3'b110 : 3'b111;
        bus.A     = a;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        if (to_hi) hi_m = a;
        else       lo_m = a;
        @(negedge clk);
        chk("mt_busy", 32'(bus.busy), 32'd0);
        chk("mt_done", 32'(bus.done), 32'd0);
        rd("mt");
    endtask

    initial begin
        int dn;
        bus.start = 1'b0;
        bus.op    = 3'b101;
        bus.A     = '0;
        bus.B     = '0;

        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rd("rst");

        // start coincides with release: the first edge must ignore it
        @(negedge clk);
        bus.op    = 3'b110;
        bus.A     = 32'hDEAD_BEEF;
        bus.start = 1'b1;
        rst_n     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        rd("first_edge");

        run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b011, 32'h0000_0007, 32'h0000_0000, 1'b0);
        run_op(3'b010, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);
        run_op(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0);

        mt(1'b1, 32'h1234_5678);
        mt(1'b0, 32'hCAFE_F00D);
        run_op(3'b010, 32'h0000_0010, 32'h0000_0000, 1'b0);

        run_op(3'b000, 32'h0000_0003, 32'h0000_0005, 1'b1);
        run_op(3'b011, 32'h0000_03E8, 32'h0000_0007, 1'b1);

        // mfhi/mflo with start are read-only
        bus.op    = 3'b100;
        bus.A     = 32'h5555_5555;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("mf_busy", 32'(bus.busy), 32'd0);
        rd("mf_start");

        // reset during a divide aborts it without a commit
        bus.op    = 3'b010;
        bus.A     = 32'h0000_0064;
        bus.B     = 32'h0000_0003;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        hi_m  = '0;
        lo_m  = '0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        rd("abort");
        dn = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        rst_n = 1'b1;
        repeat (DLAT + 2) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        chk("abort_quiet", 32'(dn), 32'd0);
        rd("abort_after");

        run_op(3'b000, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_op(3'($urandom_range(0, 3)), $urandom, $urandom, i[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
